// File: rtl/instr_buffer_loader.sv
// instr_buffer_loader: fetches a program from memory into an instruction buffer,
// one word per FETCH/WRITE pair, stopping at a null word or a full buffer.
// Ports:
//   clk, rst          clock, async active-low reset
//   start, base_addr  load request (IDLE only) and first program address
//   mem_req/mem_addr  read request and address to program memory
//   mem_ack/mem_rdata memory handshake and returned word
//   Instr_in          registered word presented to the buffer
//   buffer_index      registered buffer slot being written
//   busy, done        load in progress / one-cycle completion pulse
//   count             non-zero words loaded by the last or current load
module instr_buffer_loader #(
  parameter int unsigned Instr_word_size = 16,
  parameter int unsigned bs              = 16,
  parameter int unsigned AW              = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AW-1:0]              base_addr,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  input  logic                       mem_ack,
  input  logic [Instr_word_size-1:0] mem_rdata,
  output logic [Instr_word_size-1:0] Instr_in,
  output logic [$clog2(bs)-1:0]      buffer_index,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(bs):0]        count
);

  localparam int unsigned IDXW = $clog2(bs);
  localparam int unsigned CW   = IDXW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, FINISH} state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [Instr_word_size-1:0] instr_d;
  logic [IDXW-1:0]            idx_d;
  logic [CW-1:0]              count_d;
  logic                       mem_req_d, busy_d, done_d;
  logic                       null_word, last_slot;

  assign null_word = (Instr_in == '0);
  assign last_slot = (buffer_index == IDXW'(bs - 1));
  assign mem_addr  = addr_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (mem_ack) state_d = WRITE;
      WRITE:   state_d = (null_word || last_slot) ? FINISH : FETCH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless updated
  always_comb begin
    addr_d    = addr_q;
    instr_d   = Instr_in;
    idx_d     = buffer_index;
    count_d   = count;
    mem_req_d = mem_req;
    busy_d    = busy;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          idx_d     = '0;
          count_d   = '0;
          busy_d    = 1'b1;
          mem_req_d = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          instr_d   = mem_rdata;
          mem_req_d = 1'b0;
        end
      end
      WRITE: begin
        if (null_word) begin
          // Null word ends the program; it still occupies the slot
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          count_d = count + CW'(1);
          if (last_slot) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            idx_d     = buffer_index + IDXW'(1);
            addr_d    = addr_q + AW'(1);
            mem_req_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      Instr_in     <= '0;
      buffer_index <= '0;
      count        <= '0;
      mem_req      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      Instr_in     <= instr_d;
      buffer_index <= idx_d;
      count        <= count_d;
      mem_req      <= mem_req_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_instr_buffer_loader.sv
// Self-checking bench for instr_buffer_loader: table of load scenarios plus
// hand-written sequences for start pokes and mid-load reset.
module tb_instr_buffer_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [3:0]  idx;
  logic        busy;
  logic        done;
  logic [4:0]  count;

  instr_buffer_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .Instr_in(instr), .buffer_index(idx),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: program image at prog_base, optional wait states on one fetch
  logic [15:0] prog [32];
  logic [15:0] prog_base = '0;
  logic [15:0] off;
  int          stall_word = -1;
  int          stall_len  = 0;
  int          stall_left = 0;
  int          fetch_no   = 0;
  logic        force_ack  = 1'b0;

  always_comb begin
    off       = mem_addr - prog_base;
    mem_rdata = (off < 16'd32) ? prog[off[4:0]] : 16'h0;
    mem_ack   = (mem_req && stall_left == 0) || force_ack;
  end

  always @(posedge clk) begin
    if (!rst || start) begin
      fetch_no   <= 0;
      stall_left <= 0;
    end else if (mem_req && mem_ack) begin
      fetch_no <= fetch_no + 1;
      if (fetch_no + 1 == stall_word) stall_left <= stall_len;
    end else if (mem_req && !mem_ack && stall_left > 0) begin
      stall_left <= stall_left - 1;
    end
  end

  // Monitor: buffer writes, fetch addresses, request stability, done pulses
  logic [15:0] log_data [$];
  logic [3:0]  log_idx  [$];
  logic [15:0] log_addr [$];
  logic        wr_pending = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr  = '0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_busy = 1'b0;
  logic [4:0]  done_count = '0;

  always @(negedge clk) begin
    if (!rst) begin
      wr_pending = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (wr_pending) begin
        log_data.push_back(instr);
        log_idx.push_back(idx);
      end
      if (mem_req && mem_ack) log_addr.push_back(mem_addr);
      wr_pending = mem_req && mem_ack;
      if (prev_stall) begin
        chk("stall_mem_req", {31'b0, mem_req}, 32'd1);
        chk("stall_mem_addr", {16'b0, mem_addr}, {16'b0, prev_addr});
      end
      prev_stall = mem_req && !mem_ack;
      prev_addr  = mem_addr;
      if (done) begin
        done_cnt++;
        done_cyc   = cyc;
        done_busy  = busy;
        done_count = count;
      end
    end
  end

  typedef struct {
    logic [15:0] base;
    logic [15:0] w [16];
    int          stall_word;
    int          stall_len;
    int          exp_writes;
    int          exp_count;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic clear_logs();
    log_data.delete();
    log_idx.delete();
    log_addr.delete();
    done_cnt = 0;
  endtask

  task automatic load_prog(input vec_t v);
    for (int i = 0; i < 32; i++) prog[i] = (i < 16) ? v.w[i] : 16'h0;
    prog_base  = v.base;
    stall_word = v.stall_word;
    stall_len  = v.stall_len;
  endtask

  // Pulse start for one cycle; returns the start cycle, ends at the next negedge
  task automatic do_start(input logic [15:0] b, output int s);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", nm, bound);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int s;
    int n;
    clear_logs();
    load_prog(v);
    do_start(v.base, s);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(nm, 200);
    chk({nm, "_latency"}, 32'(done_cyc - s), 32'(v.exp_lat));
    chk({nm, "_busy_at_done"}, {31'b0, done_busy}, 32'd0);
    chk({nm, "_count"}, {27'b0, done_count}, 32'(v.exp_count));
    chk({nm, "_writes"}, 32'(log_data.size()), 32'(v.exp_writes));
    n = (log_data.size() < v.exp_writes) ? log_data.size() : v.exp_writes;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", nm, i), {16'b0, log_data[i]}, {16'b0, v.w[i]});
      chk($sformatf("%s_idx%0d", nm, i), {28'b0, log_idx[i]}, 32'(i));
      chk($sformatf("%s_addr%0d", nm, i), {16'b0, log_addr[i]}, {16'b0, 16'(v.base + 16'(i))});
    end
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, "_idle_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_count_hold"}, {27'b0, count}, 32'(v.exp_count));
  endtask

  initial begin
    vec_t hv;
    int   s;
    int   n;

    // Scenario table
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 16; i++) vecs[k].w[i] = 16'h0;
      vecs[k].stall_word = -1;
      vecs[k].stall_len  = 0;
    end
    vecs[0].base = 16'h0040;
    for (int i = 0; i < 16; i++) vecs[0].w[i] = 16'h1001 + 16'(i);
    vecs[0].exp_writes = 16; vecs[0].exp_count = 16; vecs[0].exp_lat = 33;
    vecs[1].base = 16'h0100;
    vecs[1].w[0] = 16'h00AA; vecs[1].w[1] = 16'h00BB; vecs[1].w[2] = 16'h0000;
    vecs[1].w[3] = 16'h5555;
    vecs[1].exp_writes = 3; vecs[1].exp_count = 2; vecs[1].exp_lat = 7;
    vecs[2].base = 16'h0300;
    for (int i = 0; i < 4; i++) vecs[2].w[i] = 16'h2001 + 16'(i);
    vecs[2].stall_word = 1; vecs[2].stall_len = 5;
    vecs[2].exp_writes = 5; vecs[2].exp_count = 4; vecs[2].exp_lat = 16;
    vecs[3].base = 16'hFFFE;
    vecs[3].w[0] = 16'h0001; vecs[3].w[1] = 16'h0002; vecs[3].w[2] = 16'h0003;
    vecs[3].exp_writes = 4; vecs[3].exp_count = 3; vecs[3].exp_lat = 9;
    vecs[4].base = 16'h0010;
    vecs[4].w[1] = 16'h7777;
    vecs[4].exp_writes = 1; vecs[4].exp_count = 0; vecs[4].exp_lat = 3;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_instr", {16'b0, instr}, 32'd0);
    chk("rst_idx", {28'b0, idx}, 32'd0);
    chk("rst_count", {27'b0, count}, 32'd0);
    chk("rst_addr", {16'b0, mem_addr}, 32'd0);
    rst = 1'b1;

    for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // start pulsed during FETCH and during FINISH is ignored
    hv = vecs[1];
    hv.base = 16'h0500;
    clear_logs();
    load_prog(hv);
    do_start(16'h0500, s);
    start = 1'b1;
    base_addr = 16'h0700;
    @(negedge clk);
    start = 1'b0;
    wait_done("poke", 100);
    start = 1'b1;
    base_addr = 16'h0700;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("poke_done_pulses", 32'(done_cnt), 32'd1);
    chk("poke_busy", {31'b0, busy}, 32'd0);
    chk("poke_mem_req", {31'b0, mem_req}, 32'd0);
    chk("poke_count", {27'b0, count}, 32'd2);
    chk("poke_writes", 32'(log_data.size()), 32'd3);
    if (log_addr.size() > 0) chk("poke_first_addr", {16'b0, log_addr[0]}, 32'h0500);

    // Reset during the WRITE of word 3 abandons the load
    for (int i = 0; i < 16; i++) hv.w[i] = (i < 8) ? 16'h3001 + 16'(i) : 16'h0;
    hv.base = 16'h0800;
    hv.stall_word = -1;
    clear_logs();
    load_prog(hv);
    do_start(16'h0800, s);
    repeat (5) @(negedge clk);
    #2;
    chk("pre_rst_idx", {28'b0, idx}, 32'd2);
    rst = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_instr", {16'b0, instr}, 32'd0);
    chk("arst_idx", {28'b0, idx}, 32'd0);
    chk("arst_count", {27'b0, count}, 32'd0);
    chk("arst_addr", {16'b0, mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("stray_ack_busy", {31'b0, busy}, 32'd0);
    chk("stray_ack_req", {31'b0, mem_req}, 32'd0);
    chk("stray_ack_instr", {16'b0, instr}, 32'd0);
    chk("rst_no_done", 32'(done_cnt), 32'd0);

    // Fresh load from a new base after reset
    for (int i = 0; i < 16; i++) hv.w[i] = 16'h0;
    hv.w[0] = 16'h4001;
    hv.w[1] = 16'h4002;
    hv.base = 16'h0900;
    clear_logs();
    load_prog(hv);
    do_start(16'h0900, s);
    wait_done("reload", 100);
    chk("reload_latency", 32'(done_cyc - s), 32'd7);
    chk("reload_count", {27'b0, done_count}, 32'd2);
    n = log_data.size();
    chk("reload_writes", 32'(n), 32'd3);
    if (n > 0) begin
      chk("reload_idx0", {28'b0, log_idx[0]}, 32'd0);
      chk("reload_addr0", {16'b0, log_addr[0]}, 32'h0900);
      chk("reload_data0", {16'b0, log_data[0]}, 32'h4001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
